// File: rtl/maddsub_pkg.sv
// Shared definitions for the segmented multi-cycle adder/subtractor:
// controller state encoding and the default operand/segment widths.
package maddsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_SEG_W = 16;

endpackage

// File: rtl/maddsub_segmented_addsub.sv
// One SEG_W-bit slice of the segmented adder: adds A to B (or to ~B when
// subtracting) plus a carry, and reports the carry out of the slice.
module addsub_segment #(
  parameter int SEG_W = 16
) (
  input  logic [SEG_W-1:0] i_a,
  input  logic [SEG_W-1:0] i_b,
  input  logic             i_invertB,
  input  logic             i_carryIn,
  output logic [SEG_W-1:0] o_sum,
  output logic             o_carryOut
);

  logic [SEG_W-1:0] w_bEff;
  logic [SEG_W:0]   w_total;

  // Subtraction is done as A + ~B + carry, so B is optionally inverted here
  always_comb begin
    w_bEff  = i_invertB ? ~i_b : i_b;
    w_total = {1'b0, i_a} + {1'b0, w_bEff} + {{SEG_W{1'b0}}, i_carryIn};
  end

  assign o_sum      = w_total[SEG_W-1:0];
  assign o_carryOut = w_total[SEG_W];

endmodule

// File: rtl/maddsub_segmented.sv
// Multi-cycle WIDTH-bit add/subtract with a WIDTH+1-bit result. One SEG_W-bit
// segment is processed per cycle (LSB first) through a single narrow slice;
// the extension bit is formed from the operand sign bits and the final carry.
module maddsub_segmented
  import maddsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SEG_W = DEFAULT_SEG_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic             subtract,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             overflow
);

  localparam int NSEG  = WIDTH / SEG_W;
  localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

  if (((WIDTH % SEG_W) != 0) || (SEG_W < 2)) begin : g_badParams
    $error("maddsub_segmented: WIDTH must be a multiple of SEG_W and SEG_W >= 2");
  end

  state_t           r_state;
  state_t           w_nextState;
  logic             w_inReady;
  logic             w_outValid;
  logic [IDX_W-1:0] r_segIdx;
  logic             r_carry;
  logic             r_sign;
  logic             r_sub;
  logic             r_aTop;
  logic             r_bTop;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   r_sum;
  logic             r_overflow;

  logic             w_accept;
  logic             w_lastSeg;
  logic [SEG_W-1:0] w_segSum;
  logic             w_segCout;
  logic             w_extA;
  logic             w_extB;
  logic             w_topBit;
  logic [WIDTH-1:0] w_low;
  logic [WIDTH:0]   w_result;

  assign w_accept  = in_valid && w_inReady;
  assign w_lastSeg = (r_segIdx == LAST_IDX);

  addsub_segment #(
    .SEG_W(SEG_W)
  ) u_segment (
    .i_a        (r_a[SEG_W-1:0]),
    .i_b        (r_b[SEG_W-1:0]),
    .i_invertB  (r_sub),
    .i_carryIn  (r_carry),
    .o_sum      (w_segSum),
    .o_carryOut (w_segCout)
  );

  // Bit WIDTH is a one-bit add of the extended sign bits and the last carry
  assign w_extA   = r_sign & r_aTop;
  assign w_extB   = r_sub ? ~(r_sign & r_bTop) : (r_sign & r_bTop);
  assign w_topBit = w_extA ^ w_extB ^ w_segCout;
  assign w_result = {w_topBit, w_low};

  if (NSEG == 1) begin : g_singleSeg
    assign w_low = w_segSum;
  end else begin : g_multiSeg
    logic [WIDTH-SEG_W-1:0] r_acc;

    assign w_low = {w_segSum, r_acc};

    // Finished segments shift in from the top so the last one completes the word
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_acc <= '0;
      end else if (r_state == CALC) begin
        r_acc <= w_low[WIDTH-1:SEG_W];
      end
    end
  end

  // Controller state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake outputs decoded from the current state
  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (in_valid) begin
          w_nextState = CALC;
        end
      end
      CALC: begin
        if (w_lastSeg) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_outValid = 1'b1;
        if (out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Capture the request, walk the operand segments, publish the final result
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_segIdx   <= '0;
      r_carry    <= 1'b0;
      r_sign     <= 1'b0;
      r_sub      <= 1'b0;
      r_aTop     <= 1'b0;
      r_bTop     <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_sum      <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_segIdx <= '0;
      r_carry  <= subtract ? ~carry_in : carry_in;
      r_sign   <= sign;
      r_sub    <= subtract;
      r_aTop   <= a[WIDTH-1];
      r_bTop   <= b[WIDTH-1];
      r_a      <= a;
      r_b      <= b;
    end else if (r_state == CALC) begin
      r_a     <= r_a >> SEG_W;
      r_b     <= r_b >> SEG_W;
      r_carry <= w_segCout;
      if (w_lastSeg) begin
        r_segIdx   <= '0;
        r_sum      <= w_result;
        r_overflow <= r_sign ? (w_result[WIDTH] ^ w_result[WIDTH-1]) : w_result[WIDTH];
      end else begin
        r_segIdx <= r_segIdx + 1'b1;
      end
    end
  end

  assign in_ready  = w_inReady;
  assign out_valid = w_outValid;
  assign sum       = r_sum;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_maddsub_segmented.sv
// Directed self-checking bench for maddsub_segmented at WIDTH=64, SEG_W=16.
// Expected sums are hand-computed 65-bit constants.
module tb_maddsub_segmented;

  localparam int WIDTH = 64;
  localparam int SEG_W = 16;

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic             sign;
  logic             subtract;
  logic             carry_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             overflow;

  int checkCount;
  int failCount;
  int latency;
  logic [WIDTH:0] heldSum;

  maddsub_segmented #(
    .WIDTH(WIDTH),
    .SEG_W(SEG_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .subtract  (subtract),
    .carry_in  (carry_in),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .overflow  (overflow)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Every comparison funnels through here so counting stays in one place
  task automatic checkOutput(input string tag, input logic [WIDTH:0] actual,
                             input logic [WIDTH:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one request while idle and hold it across the accepting edge
  task automatic applyStimulus(input logic s, input logic sub, input logic cin,
                               input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB);
    sign     = s;
    subtract = sub;
    carry_in = cin;
    a        = opA;
    b        = opB;
    in_valid = 1'b1;
    checkOutput("ready_before_accept", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges after acceptance until out_valid, giving up after 20
  task automatic waitResult(output int edges);
    edges = 0;
    while (!out_valid && edges < 20) begin
      @(posedge clock);
      #1;
      edges++;
    end
  endtask

  // Full transaction: request, latency, result, then consumer acceptance
  task automatic runOp(input string tag, input logic s, input logic sub, input logic cin,
                       input logic [WIDTH-1:0] opA, input logic [WIDTH-1:0] opB,
                       input logic [WIDTH:0] expSum, input logic expOv);
    int lat;
    applyStimulus(s, sub, cin, opA, opB);
    waitResult(lat);
    checkOutput({tag, "_latency"}, (WIDTH+1)'(lat), (WIDTH+1)'(4));
    checkOutput({tag, "_sum"}, sum, expSum);
    checkOutput({tag, "_overflow"}, (WIDTH+1)'(overflow), (WIDTH+1)'(expOv));
    checkOutput({tag, "_ready_busy"}, (WIDTH+1)'(in_ready), (WIDTH+1)'(0));
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_ready_after"}, (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
    checkOutput({tag, "_valid_after"}, (WIDTH+1)'(out_valid), (WIDTH+1)'(0));
  endtask

  // Safety net so a stuck design can never hang the run
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    checkCount = 0;
    failCount  = 0;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    sign       = 1'b0;
    subtract   = 1'b0;
    carry_in   = 1'b0;
    a          = '0;
    b          = '0;

    #3;
    checkOutput("reset_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
    checkOutput("reset_out_valid", (WIDTH+1)'(out_valid), (WIDTH+1)'(0));
    checkOutput("reset_sum", sum, '0);
    checkOutput("reset_overflow", (WIDTH+1)'(overflow), (WIDTH+1)'(0));

    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    runOp("uadd_carryout", 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,
          65'h1_0000_0000_0000_0000, 1'b1);
    runOp("ssub_zero_minus_one", 1'b1, 1'b1, 1'b0, 64'h0, 64'h1,
          65'h1_FFFF_FFFF_FFFF_FFFF, 1'b0);
    runOp("sadd_pos_overflow", 1'b1, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1,
          65'h0_8000_0000_0000_0000, 1'b1);
    runOp("usub_with_borrow", 1'b0, 1'b1, 1'b1, 64'h5, 64'h3,
          65'h1, 1'b0);
    runOp("uadd_cin_ripple", 1'b0, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h0,
          65'h0_0000_0001_0000_0000, 1'b0);
    runOp("ssub_neg_overflow", 1'b1, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h1,
          65'h1_7FFF_FFFF_FFFF_FFFF, 1'b1);
    runOp("sadd_minus_two", 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          65'h1_FFFF_FFFF_FFFF_FFFE, 1'b0);

    // Backpressure: result must hold and new requests must be ignored
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
    waitResult(latency);
    checkOutput("bp_latency", (WIDTH+1)'(latency), (WIDTH+1)'(4));
    heldSum = 65'h0_1234_5678_9ABC_DF00;
    checkOutput("bp_sum", sum, heldSum);
    checkOutput("bp_overflow", (WIDTH+1)'(overflow), (WIDTH+1)'(0));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = 64'(i + 100);
      b        = 64'(i * 7);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      checkOutput("bp_hold_sum", sum, heldSum);
      checkOutput("bp_hold_overflow", (WIDTH+1)'(overflow), (WIDTH+1)'(0));
      checkOutput("bp_hold_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(0));
      checkOutput("bp_hold_out_valid", (WIDTH+1)'(out_valid), (WIDTH+1)'(1));
    end
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    checkOutput("bp_release_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
    checkOutput("bp_release_out_valid", (WIDTH+1)'(out_valid), (WIDTH+1)'(0));
    checkOutput("bp_idle_sum_kept", sum, heldSum);

    // Asynchronous reset two cycles into CALC, applied between clock edges
    applyStimulus(1'b0, 1'b0, 1'b0, 64'h10, 64'h20);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_in_ready", (WIDTH+1)'(in_ready), (WIDTH+1)'(1));
    checkOutput("midreset_out_valid", (WIDTH+1)'(out_valid), (WIDTH+1)'(0));
    checkOutput("midreset_sum", sum, '0);
    checkOutput("midreset_overflow", (WIDTH+1)'(overflow), (WIDTH+1)'(0));
    repeat (3) begin
      @(posedge clock);
      #1;
      checkOutput("midreset_no_partial", (WIDTH+1)'(out_valid), (WIDTH+1)'(0));
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    runOp("post_reset_add", 1'b0, 1'b0, 1'b0, 64'h3, 64'h4, 65'h7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
